// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and helpers for the instruction-memory load path
//
// Purpose: load-controller state encoding, word-offset width calculation and the
// word-alignment mask helper shared by the loader, the memory and the fetch logic.
// Ports: none (package).

package imem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } load_state_t;

  // Widest address the mask helper serves; callers take the low bits they need.
  localparam int MASK_W = 64;

  // Number of byte-offset bits inside one instruction word.
  function automatic int calc_offbits(input int bitwidth);
    return $clog2(bitwidth / 8);
  endfunction

  // All ones except the low offbits bits: ANDing an address with this keeps
  // only the word-aligned part.
  function automatic logic [MASK_W-1:0] align_mask(input int offbits);
    return ~((MASK_W'(1) << offbits) - MASK_W'(1));
  endfunction

endpackage

// File: rtl/imem_load_check.sv
// rtl/imem_load_check.sv - combinational alignment and bounds check for a load request
//
// Purpose: decides whether a block of num_words_i words starting at byte address
// base_addr_i is word aligned and fits inside the instruction memory.
// Ports:
//   base_addr_i  byte address of the first word
//   num_words_i  number of words in the request
//   ok_o         request is aligned and in bounds
//   zero_len_o   request carries no words

module imem_load_check
  import imem_pkg::*;
#(
  parameter int ADDRSIZE = 256,
  parameter int BITWIDTH = 32
) (
  input  logic [BITWIDTH-1:0] base_addr_i,
  input  logic [BITWIDTH-1:0] num_words_i,
  output logic                ok_o,
  output logic                zero_len_o
);

  localparam int                 OFFBITS    = calc_offbits(BITWIDTH);
  localparam logic [MASK_W-1:0]  MASK_FULL  = align_mask(OFFBITS);
  localparam logic [BITWIDTH-1:0] ALIGN_MASK = MASK_FULL[BITWIDTH-1:0];
  localparam logic [BITWIDTH:0]  LIMIT      = (BITWIDTH+1)'(ADDRSIZE);

  logic                aligned;
  logic [BITWIDTH:0]   end_word;

  assign aligned  = (base_addr_i & ~ALIGN_MASK) == '0;
  // One extra bit so a huge num_words cannot wrap back into range.
  assign end_word = {1'b0, base_addr_i >> OFFBITS} + {1'b0, num_words_i};

  assign ok_o       = aligned && (end_word <= LIMIT);
  assign zero_len_o = (num_words_i == '0);

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - program-load controller for the instruction memory
//
// Purpose: accepts host instruction words over valid/ready and writes them to the
// instruction memory at consecutive word addresses from a programmed base, stalling
// core fetch while the load runs and reporting done or error.
// Ports:
//   clock, reset         system clock, synchronous active-high reset
//   start, abort         begin a load / cancel a running load
//   base_addr, num_words load request, captured on an accepted start
//   in_data, in_valid    host word stream; in_ready is the loader's ready
//   write_addr/data/valid instruction-memory write port (one cycle after accept)
//   core_stall, busy     fetch hold and load-in-progress indications
//   done, error          outcome of the last load, held until the next start

module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDRSIZE = 256,
  parameter int BITWIDTH = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [BITWIDTH-1:0] base_addr,
  input  logic [BITWIDTH-1:0] num_words,
  input  logic [BITWIDTH-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [BITWIDTH-1:0] write_addr,
  output logic [BITWIDTH-1:0] write_data,
  output logic                write_valid,
  output logic                core_stall,
  output logic                busy,
  output logic                done,
  output logic                error
);

  localparam int WORDBYTES = BITWIDTH / 8;

  load_state_t         state_q, state_d;
  logic [BITWIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [BITWIDTH-1:0] remaining_q, remaining_d;
  logic                wr_valid_q, wr_valid_d;
  logic [BITWIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [BITWIDTH-1:0] wr_data_q, wr_data_d;

  logic req_ok;
  logic req_zero;

  imem_load_check #(
    .ADDRSIZE (ADDRSIZE),
    .BITWIDTH (BITWIDTH)
  ) u_check (
    .base_addr_i (base_addr),
    .num_words_i (num_words),
    .ok_o        (req_ok),
    .zero_len_o  (req_zero)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    case (state_q)
      ST_LOAD: begin
        // abort wins over a beat presented in the same cycle.
        if (abort) begin
          state_d = ST_ERR;
        end else if (in_valid) begin
          wr_valid_d  = 1'b1;
          wr_addr_d   = cur_addr_q;
          wr_data_d   = in_data;
          cur_addr_d  = cur_addr_q + BITWIDTH'(WORDBYTES);
          remaining_d = remaining_q - BITWIDTH'(1);
          if (remaining_q == BITWIDTH'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      default: begin
        if (start) begin
          if (!req_ok) begin
            state_d = ST_ERR;
          end else if (req_zero) begin
            state_d = ST_DONE;
          end else begin
            state_d     = ST_LOAD;
            cur_addr_d  = base_addr;
            remaining_d = num_words;
          end
        end
      end
    endcase
  end

  assign in_ready    = (state_q == ST_LOAD);
  assign busy        = (state_q == ST_LOAD);
  // Stall covers the trailing write that lands after the state has left LOAD.
  assign core_stall  = (state_q == ST_LOAD) || wr_valid_q;
  assign done        = (state_q == ST_DONE);
  assign error       = (state_q == ST_ERR);
  assign write_valid = wr_valid_q;
  assign write_addr  = wr_addr_q;
  assign write_data  = wr_data_q;

endmodule
